// File: rtl/vote_ballot_collector.sv
`default_nettype none
// ============================================================================
// Module   : vote_ballot_collector
// Brief    : Collects one ballot per voter ID over valid/ready and presents the
//            assembled vote vector on close (full collection or timeout).
// Revision : 1.0 - initial release
// ============================================================================
module vote_ballot_collector #(
    parameter int VEC_W          = 16,
    parameter int ID_W           = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ballot_valid,
    output logic             ballot_ready,
    input  logic [ID_W-1:0]  ballot_id,
    input  logic             ballot_vote,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] p_vector,
    output logic [4:0]       missing_cnt,
    output logic             dup_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    localparam logic [15:0] c_timer_last = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] c_timer_max  = 16'(TIMEOUT_CYCLES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [VEC_W-1:0]   r_mask;
    logic [VEC_W-1:0]   r_vector;
    logic [15:0]        r_timer;
    logic [4:0]         r_missing;
    logic               r_dup;

    logic [VEC_W-1:0]   w_onehot;
    logic               w_accept;
    logic               w_take;
    logic               w_is_dup;
    logic [VEC_W-1:0]   w_mask_upd;
    logic [VEC_W-1:0]   w_vector_upd;
    logic               w_close;
    logic [4:0]         w_missing_upd;

    function automatic logic [4:0] f_popcount(input logic [VEC_W-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < VEC_W; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    assign ballot_ready = (r_state == S_COLLECT);
    assign out_valid    = (r_state == S_PRESENT);
    assign busy         = (r_state != S_IDLE);
    assign p_vector     = r_vector;
    assign missing_cnt  = r_missing;
    assign dup_err      = r_dup;

    assign w_onehot  = {{(VEC_W-1){1'b0}}, 1'b1} << ballot_id;
    assign w_accept  = ballot_valid & ballot_ready;
    assign w_take    = w_accept & ~r_mask[ballot_id];
    assign w_is_dup  = w_accept &  r_mask[ballot_id];

    // Close decision sees the ballot accepted this very cycle.
    always_comb begin
        w_mask_upd   = r_mask;
        w_vector_upd = r_vector;
        if (w_take) begin
            w_mask_upd   = r_mask | w_onehot;
            w_vector_upd = ballot_vote ? (r_vector | w_onehot) : (r_vector & ~w_onehot);
        end
        w_close       = (&w_mask_upd) | (r_timer == c_timer_last);
        w_missing_upd = f_popcount(~w_mask_upd);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start)     w_state_nxt = S_COLLECT;
            S_COLLECT: if (w_close)   w_state_nxt = S_PRESENT;
            S_PRESENT: if (out_ready) w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            r_vector  <= '0;
            r_timer   <= '0;
            r_missing <= '0;
            r_dup     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dup   <= w_is_dup;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mask   <= '0;
                        r_vector <= '0;
                        r_timer  <= '0;
                    end
                end
                S_COLLECT: begin
                    r_mask   <= w_mask_upd;
                    r_vector <= w_vector_upd;
                    if (r_timer != c_timer_max) begin
                        r_timer <= r_timer + 16'd1;
                    end
                    if (w_close) begin
                        r_missing <= w_missing_upd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/vote_ballot_collector.md
Name: vote_ballot_collector

Overview:
- Upstream feeder for the single-output voting comparator, which consumes a 16-bit ballot vector.
- Bit 0 is the chair/tie-break bit. Bits 1..15 are individual voter bits.
- Accepts ballots one at a time over a valid/ready stream, tracks which IDs have voted, and rejects duplicates.
- Closes the round on full collection or on timeout, then presents the assembled vector with a valid/ready handshake.

Parameters:
- VEC_W, 16, ballot vector width; fixed at 16 for the downstream comparator.
- ID_W, 4, ballot ID width; must equal log2(VEC_W).
- TIMEOUT_CYCLES, 255, number of COLLECT cycles before a forced close; legal range 1..65535.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that opens a voting round.
- ballot_valid  in  1  a ballot is offered.
- ballot_ready  out  1  the collector can accept a ballot.
- ballot_id  in  ID_W  voter index; 0 is the chair/tie-break.
- ballot_vote  in  1  vote value.
- out_valid  out  1  the assembled vector is available.
- out_ready  in  1  the downstream comparator accepts the vector.
- p_vector  out  VEC_W  assembled ballots; bit i is the vote of ID i.
- missing_cnt  out  5  number of IDs that had not voted at close (0..16).
- dup_err  out  1  one-cycle pulse when a duplicate ballot is dropped.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - state=IDLE.
  - ballot_ready=0, out_valid=0, p_vector=0, missing_cnt=0, dup_err=0, busy=0.
  - recv_mask=0, timer=0.
- States: IDLE, COLLECT, PRESENT.
- IDLE:
  - ballot_ready=0; any ballot_valid is ignored (not consumed).
  - start=1 → COLLECT on the next cycle; recv_mask, p_vector and timer are cleared.
- COLLECT:
  - ballot_ready=1 combinationally from the state register only; it is independent of ballot_valid.
  - On accept (ballot_valid & ballot_ready):
    - If recv_mask[id]=0: set p_vector[id]=ballot_vote and recv_mask[id]=1.
    - Else: drop the ballot, leave p_vector unchanged, and pulse dup_err=1 in the next cycle.
  - timer increments every COLLECT cycle, saturating at TIMEOUT_CYCLES.
  - The mask update includes the ballot accepted in the current cycle.
  - Close condition, evaluated on the updated mask: mask all-ones, or timer==TIMEOUT_CYCLES-1 in this cycle.
    - On close → PRESENT on the next edge.
    - missing_cnt is registered as the popcount of the inverted updated mask.
    - Unreceived bits stay 0 (abstain-as-no).
  - A ballot accepted on the closing cycle is included.
  - start in COLLECT is ignored.
- PRESENT:
  - out_valid=1, ballot_ready=0.
  - p_vector and missing_cnt are held stable until handshake.
  - out_valid & out_ready → IDLE on the next edge.
  - out_valid is never withdrawn before handshake.
  - p_vector and missing_cnt keep their values in IDLE until the next start.
  - start in PRESENT is ignored.
- Latency:
  - The first ballot can be accepted 1 cycle after start.
  - out_valid rises 1 cycle after the closing accept or timeout cycle.
  - Minimum round: start + 16 ballots + 1 cycle = out_valid 17 cycles after start.
- rst_n asserted mid-round: immediate abort to the reset values; no partial vector is emitted.
- Widths: timer is 16 bits. missing_cnt is 5 bits to represent 16 (the timeout case with no ballots).

Test Plan:
- Full round, in-order IDs 0..15, votes = id[0] → out_valid 17 cycles after start, p_vector=16'hAAAA, missing_cnt=0.
- Duplicate: id 3 with vote 1, then id 3 with vote 0 → dup_err pulses once, p_vector[3]=1, and the round still needs IDs 0–2 and 4–15 to close early.
- Timeout, TIMEOUT_CYCLES=20, only IDs 1, 2, 5 voting 1 → close at cycle 20, p_vector=16'h0026, missing_cnt=13.
- Backpressure: out_ready held 0 for 10 cycles in PRESENT → out_valid stays 1, p_vector stable, ballot_ready=0, and a start pulse is ignored; out_ready=1 → IDLE next cycle.
- Zero-ballot timeout, TIMEOUT_CYCLES=1 → PRESENT with p_vector=0, missing_cnt=16.
- rst_n low after 7 ballots → all outputs return to reset values immediately; a following start begins with an empty mask, and a full 16-ballot round reproduces the expected vector.
